reg_file_sync: RTL and testbench
================================

Name: reg_file_sync

Overview:
- Clocked, parametrised register file: one write port, two read ports with registered outputs, write-first bypass.
- Built-in hardware clear engine zeroes every entry after reset or on request.
- Drop-in datapath storage for the CPU core. Synchronous, edge-triggered design, unlike the older latch-based 16x8 file.

Parameters:
- WIDTH, 8, data bits per entry
- DEPTH, 16, number of entries (2..256; need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width (derived; never overridden)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  WIDTH  write data
- raddr1  input  ADDR_W  read port 1 address
- raddr2  input  ADDR_W  read port 2 address
- rdata1  output  WIDTH  read port 1 data, registered
- rdata2  output  WIDTH  read port 2 data, registered
- clr_req  input  1  request a full clear (single-cycle pulse or level)
- busy  output  1  high while the clear engine runs

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- While rst is asserted:
  - FSM = CLEAR, clear pointer = 0, busy = 1.
  - rdata1 = rdata2 = 0.
  - Storage array is not reset directly; the clear engine zeroes it.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle writes 0 to entry[ptr], then ptr++. On the cycle ptr == DEPTH-1 is written, next state is IDLE and busy drops.
  - The clear takes exactly DEPTH cycles after rst deasserts.
  - IDLE: clr_req == 1 -> next state CLEAR with ptr = 0 and busy = 1 the next cycle.
  - clr_req is ignored while already in CLEAR; the clear does not restart.
- Reset asserted mid-clear: immediately returns to CLEAR with ptr = 0. The full DEPTH-cycle clear is repeated.
- Writes:
  - In IDLE, we == 1 and waddr < DEPTH -> entry[waddr] <= wdata at the rising edge.
  - waddr >= DEPTH -> write dropped.
  - we is ignored while busy; no write occurs and no error is flagged.
- Reads:
  - Latency 1. At edge N, rdataK <= entry[raddrK] as sampled at edge N.
  - busy == 1 -> rdataK <= 0.
  - raddrK >= DEPTH -> rdataK <= 0.
- Bypass (write-first): in IDLE with we == 1 and waddr == raddrK < DEPTH in the same cycle, rdataK <= wdata, the new value.
- Both read ports may address the same entry, each other, or the write address. All combinations are legal and independent.
- The cycle busy falls, a write is already accepted; there is no dead cycle.
- No X propagation: after the first clear completes, every readable entry is defined.

Optional Feature:
- Macro: REG_FILE_ZERO_REG_EN.
- Defined:
  - Entry 0 is hardwired zero. Writes to address 0 are dropped, reads of address 0 return 0, and no bypass applies to address 0.
  - Storage for entry 0 is not instantiated, and the clear engine still takes DEPTH cycles.
- Undefined: entry 0 is an ordinary entry.

Test Plan:
- Reset then clear (WIDTH=8, DEPTH=16):
  - Pulse rst, release, hold we = 1 with waddr = 3, wdata = 0xAA.
  - busy stays 1 for exactly 16 cycles.
  - Reads of all addresses return 0x00 afterwards, and entry 3 remains 0x00 because writes are dropped while busy.
- Basic write/read:
  - Write 0x5A to entry 7, then the next cycle set raddr1 = 7 and raddr2 = 7.
  - One cycle later, rdata1 = rdata2 = 0x5A.
- Bypass:
  - Same cycle: we = 1, waddr = 4, wdata = 0x3C, raddr1 = 4, raddr2 = 5, with entry 5 holding 0x11.
  - Next cycle: rdata1 = 0x3C, rdata2 = 0x11.
- Clear request and mid-clear reset:
  - Fill entries with 0xFF, pulse clr_req.
  - After 5 busy cycles, assert rst for 1 cycle.
  - busy stays high 16 cycles after release, then all entries read 0x00.
- Out-of-range (DEPTH=12):
  - Write 0x77 to address 13, then read address 13 -> 0x00.
  - Addresses 0..11 are unchanged.
- Zero register (REG_FILE_ZERO_REG_EN defined):
  - Write 0x99 to address 0 with raddr1 = 0 in the same cycle -> rdata1 = 0x00 next cycle and on every later read.
  - Without the macro, the same stimulus gives 0x99.

Source files
------------

// File: rtl/reg_file_sync.sv
// Parametrised register file: one write port, two registered read ports with write-first bypass,
// and a clear engine that zeroes every entry after reset or on clr_req. Optional macro: REG_FILE_ZERO_REG_EN.
module reg_file_sync #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata1,
  output logic [WIDTH-1:0]  rdata2,
  input  logic              clr_req,
  output logic              busy
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;

  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
  localparam int LO       = 1;
`else
  localparam bit ZERO_REG = 1'b0;
  localparam int LO       = 0;
`endif

  // Entry 0 has no storage when it is the hardwired zero register.
  logic [WIDTH-1:0]  mem [LO:DEPTH-1];
  logic [0:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic              wr_en;
  logic              clr_wr;
  logic [WIDTH-1:0]  rd1_nx;
  logic [WIDTH-1:0]  rd2_nx;

  function automatic logic readable(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_W) && !(ZERO_REG && (a == '0));
  endfunction

  assign busy   = (state == CLEAR);
  assign wr_en  = !busy && we && readable(waddr);
  assign clr_wr = busy && !(ZERO_REG && (ptr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else if (state == CLEAR) begin
      if (ptr == LAST) begin
        state <= IDLE;
        ptr   <= '0;
      end else begin
        ptr <= ptr + ADDR_W'(1);
      end
    end else if (clr_req) begin
      state <= CLEAR;
      ptr   <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem[ptr] <= '0;
    end else if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rd1_nx = '0;
    rd2_nx = '0;
    if (!busy && readable(raddr1)) begin
      rd1_nx = (we && (waddr == raddr1)) ? wdata : mem[raddr1];
    end
    if (!busy && readable(raddr2)) begin
      rd2_nx = (we && (waddr == raddr2)) ? wdata : mem[raddr2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata1 <= '0;
      rdata2 <= '0;
    end else begin
      rdata1 <= rd1_nx;
      rdata2 <= rd2_nx;
    end
  end

endmodule

// File: tb/tb_reg_file_sync.sv
// Self-checking bench for reg_file_sync: DEPTH=16 and DEPTH=12 instances share one stimulus stream
// and are compared each cycle against an array-based reference model, plus directed vectors.
module tb_reg_file_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we = 1'b0;
  logic       clr_req = 1'b0;
  logic [3:0] waddr = '0;
  logic [3:0] raddr1 = '0;
  logic [3:0] raddr2 = '0;
  logic [7:0] wdata = '0;
  logic [7:0] r1_a, r2_a, r1_b, r2_b;
  logic       busy_a, busy_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_file_sync #(.WIDTH(8), .DEPTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(r1_a), .rdata2(r2_a),
    .clr_req(clr_req), .busy(busy_a)
  );

  reg_file_sync #(.WIDTH(8), .DEPTH(12)) u_dut12 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(r1_b), .rdata2(r2_b),
    .clr_req(clr_req), .busy(busy_b)
  );

`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZREG = 1'b1;
`else
  localparam bit ZREG = 1'b0;
`endif

  // Reference model: one storage array and a remaining-clear-cycles counter per instance.
  int         depth [2] = '{16, 12};
  logic [7:0] mem [2][16];
  int         clr_left [2];
  logic [7:0] exp_r1 [2];
  logic [7:0] exp_r2 [2];

  function automatic logic [7:0] model_read(input int k, input int a);
    if (a >= depth[k]) return 8'h00;
    if (ZREG && a == 0) return 8'h00;
    if (we && int'(waddr) == a) return wdata;
    return mem[k][a];
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        clr_left[k] = depth[k];
        exp_r1[k] = 8'h00;
        exp_r2[k] = 8'h00;
        for (int i = 0; i < 16; i++) mem[k][i] = 8'h00;
      end else if (clr_left[k] > 0) begin
        clr_left[k]--;
        exp_r1[k] = 8'h00;
        exp_r2[k] = 8'h00;
      end else begin
        exp_r1[k] = model_read(k, int'(raddr1));
        exp_r2[k] = model_read(k, int'(raddr2));
        if (we && int'(waddr) < depth[k] && !(ZREG && waddr == 4'd0))
          mem[k][waddr] = wdata;
        if (clr_req) begin
          clr_left[k] = depth[k];
          for (int i = 0; i < 16; i++) mem[k][i] = 8'h00;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_r1_d16", r1_a, exp_r1[0]);
    check("model_r2_d16", r2_a, exp_r2[0]);
    check("model_busy_d16", {7'b0, busy_a}, {7'b0, clr_left[0] > 0});
    check("model_r1_d12", r1_b, exp_r1[1]);
    check("model_r2_d12", r2_b, exp_r2[1]);
    check("model_busy_d12", {7'b0, busy_b}, {7'b0, clr_left[1] > 0});
  endtask

  // Steps until both instances leave CLEAR; returns edges counted per instance (-1 on timeout).
  task automatic wait_clear(output int n16, output int n12);
    int  c = 0;
    bit  d16 = 0;
    bit  d12 = 0;
    n16 = -1;
    n12 = -1;
    while (!(d16 && d12) && c < 40) begin
      step();
      c++;
      if (!d16 && !busy_a) begin d16 = 1; n16 = c; end
      if (!d12 && !busy_b) begin d12 = 1; n12 = c; end
    end
  endtask

  typedef struct {
    logic       we;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic [3:0] raddr1;
    logic [3:0] raddr2;
    logic [7:0] exp1;
    logic [7:0] exp2;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n16, n12;
    logic [7:0] v;

    vecs[0] = '{1'b1, 4'd7, 8'h5A, 4'd0,  4'd0, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 4'd0, 8'h00, 4'd7,  4'd7, 8'h5A, 8'h5A};
    vecs[2] = '{1'b1, 4'd5, 8'h11, 4'd0,  4'd0, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 4'd4, 8'h3C, 4'd4,  4'd5, 8'h3C, 8'h11};
    vecs[4] = '{1'b0, 4'd0, 8'h00, 4'd4,  4'd7, 8'h3C, 8'h5A};
    vecs[5] = '{1'b1, 4'd7, 8'hC3, 4'd7,  4'd7, 8'hC3, 8'hC3};
    vecs[6] = '{1'b1, 4'd2, 8'h01, 4'd7,  4'd2, 8'hC3, 8'h01};
    vecs[7] = '{1'b0, 4'd0, 8'h00, 4'd13, 4'd5, 8'h00, 8'h11};

    // Reset, then clear with writes held active; they must be dropped while busy.
    #1 rst = 1'b1;
    #1;
    check("rst_r1", r1_a, 8'h00);
    check("rst_busy", {7'b0, busy_a}, 8'h01);
    step();
    step();
    rst = 1'b0;
    we = 1'b1; waddr = 4'd3; wdata = 8'hAA;
    wait_clear(n16, n12);
    check_int("clear_len_d16", n16, 16);
    check_int("clear_len_d12", n12, 12);
    we = 1'b0;
    for (int a = 0; a < 16; a++) begin
      raddr1 = 4'(a); raddr2 = 4'd3;
      step();
      check("post_clear_read", r1_a, 8'h00);
      check("entry3_not_written", r2_a, 8'h00);
    end

    // Directed vectors: basic write/read and bypass.
    for (int i = 0; i < 8; i++) begin
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      raddr1 = vecs[i].raddr1; raddr2 = vecs[i].raddr2;
      step();
      check($sformatf("vec%0d_r1", i), r1_a, vecs[i].exp1);
      check($sformatf("vec%0d_r2", i), r2_a, vecs[i].exp2);
    end

    // Asynchronous reset clears outputs without a clock edge.
    we = 1'b0; raddr1 = 4'd7;
    step();
    rst = 1'b1;
    #1;
    check("async_rst_r1", r1_a, 8'h00);
    check("async_rst_busy", {7'b0, busy_a}, 8'h01);
    step();
    rst = 1'b0;
    wait_clear(n16, n12);
    check_int("clear2_len_d16", n16, 16);

    // Fill with 0xFF, request clear, reset after 5 busy cycles; clr_req held is ignored meanwhile.
    for (int a = 0; a < 16; a++) begin
      we = 1'b1; waddr = 4'(a); wdata = 8'hFF;
      step();
    end
    we = 1'b0;
    clr_req = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("clr_busy_d16", {7'b0, busy_a}, 8'h01);
    clr_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_clear(n16, n12);
    check_int("midclear_rst_len_d16", n16, 16);
    check_int("midclear_rst_len_d12", n12, 12);
    for (int a = 0; a < 16; a++) begin
      raddr1 = 4'(a); raddr2 = 4'(15 - a);
      step();
      check("cleared_entry_d16", r1_a, 8'h00);
    end

    // Out-of-range on DEPTH=12: addresses 12..15 drop writes and read back 0.
    for (int a = 0; a < 16; a++) begin
      we = 1'b1; waddr = 4'(a); wdata = 8'(a * 3 + 1);
      step();
    end
    waddr = 4'd13; wdata = 8'h77; raddr1 = 4'd13;
    step();
    check("oor_bypass_d12", r1_b, 8'h00);
    we = 1'b0;
    step();
    check("oor_read_d12", r1_b, 8'h00);
    check("inrange_read_d16", r1_a, 8'h77);
    for (int a = 0; a < 12; a++) begin
      raddr1 = 4'(a);
      step();
      v = (ZREG && a == 0) ? 8'h00 : 8'(a * 3 + 1);
      check("oor_unchanged_d12", r1_b, v);
    end

    // Zero register behaviour (address 0 write with same-cycle read).
    we = 1'b1; waddr = 4'd0; wdata = 8'h99; raddr1 = 4'd0;
    step();
    check("zero_reg_bypass", r1_a, ZREG ? 8'h00 : 8'h99);
    we = 1'b0;
    step();
    check("zero_reg_read", r1_a, ZREG ? 8'h00 : 8'h99);

    // Randomised traffic checked against the model.
    for (int i = 0; i < 3000; i++) begin
      we      = 1'($urandom_range(0, 1));
      waddr   = 4'($urandom_range(0, 15));
      wdata   = 8'($urandom);
      raddr1  = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
      raddr2  = ($urandom_range(0, 3) == 0) ? raddr1 : 4'($urandom_range(0, 15));
      clr_req = ($urandom_range(0, 79) == 0);
      rst     = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
